seq_operator: RTL and testbench

- Parametrised, clocked successor to the combinational 4-bit operator/display block.
- Latches two W-bit operands and a 3-bit opcode on a start strobe, then computes the selected operation.
- Single-cycle ops: add, sub, and, or, xor, compare. Multi-cycle ops: shift-add multiply, restoring divide.
- Reports completion with a one-cycle done pulse. Holds the operands and result for the seven-segment display path.

---
 rtl/seq_operator.sv | 182 ++++++++++++++++++
 tb/tb_seq_operator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_operator.sv
// Clocked W-bit operator: latches operands/opcode on start, runs single-cycle ALU ops
// or iterative shift-add multiply / restoring divide, and pulses done when the result is ready.
module seq_operator #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     m,
    input  logic [W-1:0]     n,
    input  logic [2:0]       choose,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   f,
    output logic             carry,
    output logic             err,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*W-1:0] f_q, f_d;
    logic           carry_q, carry_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

    logic [W:0]     add_s;
    logic [W-1:0]   sub_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     div_sh_s;
    logic           div_ge_s;
    logic [W-1:0]   div_sub_s;

    // Next-state, datapath and result selection
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        f_d     = f_q;
        carry_d = carry_q;
        err_d   = err_q;

        add_s     = {1'b0, m} + {1'b0, n};
        sub_s     = m - n;
        // {hi,lo} is the product/multiplier pair for mul, remainder/quotient pair for div
        mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        div_sh_s  = {hi_q, lo_q[W-1]};
        div_ge_s  = (div_sh_s >= {1'b0, b_q});
        div_sub_s = div_sh_s[W-1:0] - b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = m;
                    b_d   = n;
                    op_d  = choose;
                    cnt_d = '0;
                    if ((choose == OP_MUL || choose == OP_DIV) && n != '0) begin
                        state_d = S_RUN;
                        hi_d    = '0;
                        lo_d    = (choose == OP_MUL) ? n : m;
                    end else begin
                        state_d = S_FIN;
                        carry_d = 1'b0;
                        err_d   = 1'b0;
                        case (choose)
                            OP_ADD: begin
                                f_d     = {{(W-1){1'b0}}, add_s};
                                carry_d = add_s[W];
                            end
                            OP_SUB: begin
                                f_d     = {{W{1'b0}}, sub_s};
                                carry_d = (m < n);
                            end
                            OP_AND: f_d = {{W{1'b0}}, m & n};
                            OP_OR:  f_d = {{W{1'b0}}, m | n};
                            OP_XOR: f_d = {{W{1'b0}}, m ^ n};
                            OP_MUL: f_d = '0;
                            OP_DIV: begin
                                f_d   = '1;
                                err_d = 1'b1;
                            end
                            OP_CMP: f_d = {{(2*W-3){1'b0}}, (m > n), (m == n), (m < n)};
                            default: f_d = '0;
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (op_q == OP_MUL) begin
                    hi_d = mul_sum_s[W:1];
                    lo_d = {mul_sum_s[0], lo_q[W-1:1]};
                end else begin
                    hi_d = div_ge_s ? div_sub_s : div_sh_s[W-1:0];
                    lo_d = {lo_q[W-2:0], div_ge_s};
                end
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIN;
                    f_d     = {hi_d, lo_d};
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            f_q     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            f_q     <= f_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign f     = f_q;
    assign carry = carry_q;
    assign err   = err_q;
    assign a     = a_q;
    assign b     = b_q;

endmodule

// File: tb/tb_seq_operator.sv
// Scoreboard bench for seq_operator: stimulus pushes model results, a negedge monitor
// pops and compares them whenever done pulses.
module tb_seq_operator;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   m = '0;
    logic [W-1:0]   n = '0;
    logic [2:0]     choose = 3'd0;
    logic           busy, done, carry, err;
    logic [2*W-1:0] f;
    logic [W-1:0]   a, b;

    typedef struct {
        logic [2*W-1:0] f;
        logic           c;
        logic           e;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        int             busy;
        int             acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    seq_operator #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .n(n), .choose(choose),
        .busy(busy), .done(done), .f(f), .carry(carry), .err(err), .a(a), .b(b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic rules
    function automatic exp_t model(input int mi, input int ni, input int op);
        exp_t r;
        int   lim = 1 << W;
        int   fi = 0;
        r.c = 1'b0;
        r.e = 1'b0;
        case (op)
            0: begin fi = mi + ni; r.c = (mi + ni) >= lim; end
            1: begin fi = (mi - ni + lim) % lim; r.c = (mi < ni); end
            2: fi = mi & ni;
            3: fi = mi | ni;
            4: fi = mi ^ ni;
            5: fi = mi * ni;
            6: begin
                if (ni == 0) begin fi = lim * lim - 1; r.e = 1'b1; end
                else fi = (mi % ni) * lim + mi / ni;
            end
            default: fi = (mi > ni) * 4 + (mi == ni) * 2 + (mi < ni);
        endcase
        r.f    = fi[2*W-1:0];
        r.a    = mi[W-1:0];
        r.b    = ni[W-1:0];
        r.lat  = ((op == 5 || op == 6) && ni != 0) ? W + 1 : 1;
        r.busy = ((op == 5 || op == 6) && ni != 0) ? W : 0;
        r.acc  = 0;
        return r;
    endfunction

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_width", {63'd0, prev_done}, 64'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("f", {56'd0, f}, {56'd0, e.f});
                chk("carry", {63'd0, carry}, {63'd0, e.c});
                chk("err", {63'd0, err}, {63'd0, e.e});
                chk("a", {60'd0, a}, {60'd0, e.a});
                chk("b", {60'd0, b}, {60'd0, e.b});
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
            end
            busy_cnt = 0;
        end
        prev_done = done;
    end

    task automatic run_op(input int mi, input int ni, input int op, input bit repulse);
        exp_t e;
        int   base;
        int   t;
        @(negedge clk);
        m = mi[W-1:0]; n = ni[W-1:0]; choose = op[2:0]; start = 1'b1;
        @(posedge clk);
        #1;
        e = model(mi, ni, op);
        e.acc = cyc;
        sb.push_back(e);
        base = done_cnt;
        t = 0;
        while (done_cnt == base && t < 3 * W + 10) begin
            @(negedge clk);
            start = (repulse && t == 1 && e.lat > 2) ? 1'b1 : 1'b0;
            m = W'($urandom); n = W'($urandom); choose = 3'($urandom);
            t++;
        end
        start = 1'b0;
        if (done_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=done op=%0d", op);
            sb.delete();
        end
    endtask

    initial begin
        int op, mi, ni;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_f", {56'd0, f}, 64'd0);
        chk("rst_flags", {62'd0, carry, err}, 64'd0);
        chk("rst_ab", {56'd0, a, b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(12, 10, 0, 0);
        run_op(12, 10, 1, 0);
        run_op(10, 12, 1, 0);
        run_op(12, 10, 5, 0);
        run_op(15, 15, 5, 0);
        run_op(12, 10, 6, 0);
        run_op(12, 0, 6, 0);
        run_op(12, 10, 7, 0);
        run_op(10, 10, 7, 0);
        run_op(12, 10, 2, 0);
        run_op(12, 10, 3, 0);
        run_op(12, 10, 4, 0);
        run_op(9, 0, 5, 0);
        run_op(12, 10, 5, 1);
        run_op(13, 3, 6, 1);

        // Abort a multiply with rst during its second RUN cycle
        @(negedge clk);
        m = 4'd12; n = 4'd10; choose = 3'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("run_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_f", {56'd0, f}, 64'd0);
        chk("abort_ab", {54'd0, carry, err, a, b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * W) @(negedge clk);

        // rst and start together: request dropped
        m = 4'd7; n = 4'd3; choose = 3'd0; start = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_ab", {56'd0, a, b}, 64'd0);
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        repeat (4) @(negedge clk);

        run_op(12, 10, 5, 0);

        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 7));
            mi = int'($urandom_range(0, (1 << W) - 1));
            ni = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
            run_op(mi, ni, op, $urandom_range(0, 3) == 0);
        end

        repeat (3 * W) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
